qspi_xip_read_ctrl: RTL and testbench
=====================================

Name: qspi_xip_read_ctrl

Overview:
- Read-only sequencer for the quad SPI flash port (spiflash4x_clk / cs_n / dq) on the W25Q32JV-class device.
- Turns single-word read requests from the SoC bus into Fast Read Quad I/O (0xEB) transactions.
- Keeps chip-select asserted between word-sequential requests so streaming fetches skip the command, address and dummy phases.
- Sits between the instruction/data bus bridge and the pad-level tristate buffers.

Parameters:
- HOLD_CYCLES, 16: idle clk cycles cs_n stays low in HOLD waiting for a sequential request. 0 disables continuation.
- CS_HIGH_MIN, 4: minimum clk cycles cs_n stays high between transactions (tSHSL).
- DUMMY_SCLK, 4: dummy SCLK cycles after the mode byte.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request
- req_ready  out  1  request accepted when req_valid && req_ready at a rising clk edge
- req_addr  in  24  byte address; bits [1:0] ignored (word aligned)
- rsp_valid  out  1  one-cycle pulse; rsp_data valid; no backpressure
- rsp_data  out  32  read word, little-endian: byte at addr → [7:0]
- busy  out  1  high in every state except IDLE
- spi_clk  out  1  flash SCLK, mode 0, idles low
- spi_cs_n  out  1  flash chip select
- spi_dq_o  out  4  pad output data
- spi_dq_oe  out  4  per-bit output enable
- spi_dq_i  in  4  pad input data

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - Outputs during reset: spi_cs_n=1, spi_clk=0, spi_dq_oe=0000, spi_dq_o=0000, req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - A reset during any transfer aborts it immediately; no rsp_valid is issued.
  - req_ready rises the cycle after reset release.
- SCLK timing: one SCLK period = 2 clk cycles.
  - Phase L (spi_clk=0): outputs update.
  - Phase H (spi_clk=1): spi_dq_i is sampled at the clk edge that ends phase H.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, HOLD, DESEL.
- IDLE:
  - req_ready=1.
  - On accept: latch addr[23:2], spi_cs_n=0 from the next cycle, go to CMD.
- CMD, 8 SCLK:
  - 0xEB sent MSB first on dq[0].
  - oe=1101, with dq[2]=dq[3]=1 (WPn/HOLDn held high).
- ADDR, 6 SCLK:
  - {addr[23:2],2'b00} sent nibble-wise MSB first.
  - oe=1111.
- MODE, 2 SCLK:
  - Drive 0x00 (no continuous-read mode).
  - oe=1111.
- DUMMY, DUMMY_SCLK SCLK:
  - oe=0000.
- DATA, 8 SCLK:
  - oe=0000.
  - Each byte arrives high nibble first; bytes fill [7:0], [15:8], [23:16], [31:24].
  - rsp_valid pulses and rsp_data updates in the cycle after the last sample.
  - next_addr = addr+4, mod 2^24 (0xFFFFFC → 0x000000).
  - Then go to HOLD, or to DESEL if HOLD_CYCLES=0.
- HOLD:
  - spi_cs_n=0, spi_clk=0, oe=0000, req_ready=1; a counter runs from 0.
  - Accept with req_addr[23:2]==next_addr[23:2] → DATA directly; the counter resets.
  - Accept with any other address → latch it, then DESEL, then CMD. No second handshake.
  - Counter reaches HOLD_CYCLES with no accept → DESEL.
  - Accept and timeout in the same cycle: the accept wins.
- DESEL:
  - spi_cs_n=1 for CS_HIGH_MIN cycles, req_ready=0.
  - Exit to CMD if a request is latched, otherwise to IDLE.
- Latency, acceptance edge to rsp_valid:
  - New transaction: 1 + 2×(8+6+2+DUMMY_SCLK+8) = 57 clk at defaults.
  - Sequential continuation: 1 + 16 = 17 clk.
- req_ready=0 in CMD through DATA. Requests are never dropped, only stalled.
- rsp_data holds its value until the next rsp_valid.

Test Plan:
- Flash preloaded 0x00: 11 22 33 44; read 0x000000 → cs_n falls. SPI check:
  - dq0 carries 0xEB; the address nibbles are 0.
  - rsp_valid appears 57 clk after accept; rsp_data=0x44332211.
- Reads 0x000100 then 0x000104, second issued within 16 clk of rsp_valid:
  - No second command; cs_n stays low.
  - Second rsp_valid 17 clk after its accept.
- Read 0x000100, then 0x000200 during HOLD → cs_n high for exactly 4 clk, then a new 0xEB; data correct.
- Read 0x000000, no further request → cs_n rises 16 clk after rsp_valid; busy=0 after DESEL; req_ready=1.
- Read 0xFFFFFC then 0x000000 sequentially → continuation path taken (no command); both words match flash contents.
- Assert reset_n=0 mid-ADDR → same cycle: cs_n=1, spi_clk=0, oe=0000, no rsp_valid. After release, a read of 0x000000 returns 0x44332211.

Source files
------------

// File: rtl/qspi_xip_read_ctrl.sv
// Execute-in-place read sequencer: issues Fast Read Quad I/O (0xEB) for single-word
// requests and keeps chip-select low so word-sequential fetches stream straight from DATA.
module qspi_xip_read_ctrl #(
  parameter int HOLD_CYCLES = 16,
  parameter int CS_HIGH_MIN = 4,
  parameter int DUMMY_SCLK  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic [3:0]  spi_dq_o,
  output logic [3:0]  spi_dq_oe,
  input  logic [3:0]  spi_dq_i
);

  localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;
  localparam int HOLD_LAST  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int DESEL_LAST = (CS_HIGH_MIN > 0) ? CS_HIGH_MIN - 1 : 0;
  localparam int DUMMY_LAST = (DUMMY_SCLK > 0) ? DUMMY_SCLK - 1 : 0;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, HOLD, DESEL} state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  sclkCnt_q, sclkCnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [21:0] addr_q, addr_d;
  logic        pend_q, pend_d;
  logic [31:0] shift_q, shift_d;
  logic        rspValid_q, rspValid_d;
  logic [31:0] rspData_q, rspData_d;
  logic        rdyEn_q;

  logic        accept;
  logic [7:0]  sclkLast;
  logic [31:0] shiftIn;
  logic [23:0] addrFull;
  logic [4:0]  shAmt;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^req_addr[1:0];
  assign shiftIn   = {shift_q[27:0], spi_dq_i};
  assign addrFull  = {addr_q, 2'b00};
  assign shAmt     = 5'd20 - {sclkCnt_q[2:0], 2'b00};
  assign req_ready = rdyEn_q && ((state_q == IDLE) || (state_q == HOLD));
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;

  always_comb begin
    case (state_q)
      CMD:     sclkLast = 8'd7;
      ADDR:    sclkLast = 8'd5;
      MODE:    sclkLast = 8'd1;
      DUMMY:   sclkLast = 8'(DUMMY_LAST);
      default: sclkLast = 8'd7;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    sclkCnt_d  = sclkCnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    shift_d    = shift_q;
    rspValid_d = 1'b0;
    rspData_d  = rspData_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr[23:2];
          state_d = CMD;
        end
      end
      CMD, ADDR, MODE, DUMMY, DATA: begin
        phase_d = ~phase_q;
        // Everything advances at the clk edge that ends the SCLK high phase.
        if (phase_q) begin
          if (state_q == DATA) shift_d = shiftIn;
          if (sclkCnt_q == sclkLast) begin
            sclkCnt_d = '0;
            case (state_q)
              CMD:   state_d = ADDR;
              ADDR:  state_d = MODE;
              MODE:  state_d = (DUMMY_SCLK > 0) ? DUMMY : DATA;
              DUMMY: state_d = DATA;
              default: begin
                rspValid_d = 1'b1;
                rspData_d  = {shiftIn[7:0], shiftIn[15:8], shiftIn[23:16], shiftIn[31:24]};
                addr_d     = addr_q + 22'd1;
                cnt_d      = '0;
                state_d    = (HOLD_CYCLES > 0) ? HOLD : DESEL;
              end
            endcase
          end else begin
            sclkCnt_d = sclkCnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (accept) begin
          cnt_d = '0;
          if (req_addr[23:2] == addr_q) begin
            state_d = DATA;
          end else begin
            addr_d  = req_addr[23:2];
            pend_d  = 1'b1;
            state_d = DESEL;
          end
        end else if (cnt_q == 16'(HOLD_LAST)) begin
          cnt_d   = '0;
          state_d = DESEL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DESEL: begin
        if (cnt_q == 16'(DESEL_LAST)) begin
          cnt_d = '0;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = CMD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n  = 1'b0;
    spi_clk   = 1'b0;
    spi_dq_o  = '0;
    spi_dq_oe = '0;
    case (state_q)
      IDLE, DESEL: spi_cs_n = 1'b1;
      CMD: begin
        spi_clk   = phase_q;
        spi_dq_oe = 4'b1101;
        spi_dq_o  = {2'b11, 1'b0, CMD_QUAD_IO_READ[3'd7 - sclkCnt_q[2:0]]};
      end
      ADDR: begin
        spi_clk   = phase_q;
        spi_dq_oe = 4'b1111;
        spi_dq_o  = addrFull[shAmt +: 4];
      end
      MODE: begin
        spi_clk   = phase_q;
        spi_dq_oe = 4'b1111;
      end
      DUMMY, DATA: spi_clk = phase_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      sclkCnt_q  <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rdyEn_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sclkCnt_q  <= sclkCnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      shift_q    <= shift_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rdyEn_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qspi_xip_read_ctrl.sv
// Bench for qspi_xip_read_ctrl: a behavioural quad-I/O flash plus a transaction-level
// model of latency, command issue and returned data.
module tb_qspi_xip_read_ctrl;

  localparam int HOLD_CYCLES = 16;
  localparam int CS_HIGH_MIN = 4;
  localparam int DUMMY_SCLK  = 4;
  localparam int TXN_CLKS    = 2 * (8 + 6 + 2 + DUMMY_SCLK + 8);
  localparam int DATA_START  = 8 + 6 + 2 + DUMMY_SCLK;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic        spi_clk;
  logic        spi_cs_n;
  logic [3:0]  spi_dq_o;
  logic [3:0]  spi_dq_oe;
  logic [3:0]  spi_dq_i = '0;

  always #5 clk = ~clk;

  qspi_xip_read_ctrl #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CS_HIGH_MIN(CS_HIGH_MIN),
    .DUMMY_SCLK (DUMMY_SCLK)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_dq_o (spi_dq_o),
    .spi_dq_oe(spi_dq_oe),
    .spi_dq_i (spi_dq_i)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  memOv [logic [23:0]];
  int          edges = 0;
  int          cmdCount = 0;
  int          protoErr = 0;
  logic [7:0]  cmdSh = '0;
  logic [7:0]  lastCmd = '0;
  logic [23:0] addrSh = '0;
  logic [23:0] flashAddr = '0;
  int          csHighLen = 0;
  int          lastCsHigh = 0;

  function automatic logic [7:0] memByte(input logic [23:0] a);
    if (memOv.exists(a)) return memOv[a];
    return a[7:0] ^ {a[11:8], a[19:16]} ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] wordAt(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {memByte(b + 24'd3), memByte(b + 24'd2), memByte(b + 24'd1), memByte(b)};
  endfunction

  // Flash side: decode command/address on rising SCLK, shift data out on falling SCLK.
  always @(negedge spi_cs_n) edges = 0;

  always @(posedge spi_clk) begin
    if (spi_cs_n) begin
      protoErr++;
    end else begin
      edges++;
      if (edges <= 8) begin
        if (spi_dq_oe != 4'b1101 || spi_dq_o[3:2] != 2'b11) protoErr++;
        cmdSh = {cmdSh[6:0], spi_dq_o[0]};
        if (edges == 8) begin
          lastCmd = cmdSh;
          cmdCount++;
        end
      end else if (edges <= 14) begin
        if (spi_dq_oe != 4'b1111) protoErr++;
        addrSh = {addrSh[19:0], spi_dq_o};
        if (edges == 14) flashAddr = addrSh;
      end else if (edges <= 16) begin
        if (spi_dq_oe != 4'b1111 || spi_dq_o != 4'b0000) protoErr++;
      end else if (spi_dq_oe != 4'b0000) begin
        protoErr++;
      end
    end
  end

  always @(negedge spi_clk) begin
    int         fk;
    logic [7:0] fb;
    logic [3:0] fn;
    if (!spi_cs_n && edges >= DATA_START) begin
      fk = edges - DATA_START;
      fb = memByte(flashAddr + 24'(fk / 2));
      fn = (fk % 2 == 0) ? fb[7:4] : fb[3:0];
      #1 spi_dq_i = fn;
    end
  end

  always @(negedge clk) begin
    if (spi_cs_n) begin
      csHighLen++;
    end else begin
      if (csHighLen != 0) lastCsHigh = csHighLen;
      csHighLen = 0;
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic applyStimulus(input logic [23:0] a, input int expLat, input logic [31:0] expData,
                               input bit expNew, input string nm);
    int c0;
    int w;
    int n;
    c0 = cmdCount;
    req_addr  = a;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checkOutput({nm, " accept"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    checkOutput({nm, " latency"}, 32'(n), 32'(expLat));
    checkOutput({nm, " data"}, rsp_data, expData);
    checkOutput({nm, " new cmd"}, 32'(cmdCount - c0), 32'(expNew));
    if (expNew) begin
      checkOutput({nm, " opcode"}, 32'(lastCmd), 32'h0000_00EB);
      checkOutput({nm, " flash addr"}, 32'(flashAddr), 32'({a[23:2], 2'b00}));
    end
    checkOutput({nm, " protocol"}, 32'(protoErr), 32'd0);
  endtask

  typedef struct {
    logic [23:0] addr;
    int          gap;
    int          expLat;
    logic [31:0] expData;
    bit          expNew;
    int          expCsHigh;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] prevAddr;
    logic [23:0] a;
    int          gap;
    int          riseAt;
    bit          sawRsp;
    bit          cont;
    bit          inHold;
    int          lat;

    memOv[24'h000000] = 8'h11; memOv[24'h000001] = 8'h22;
    memOv[24'h000002] = 8'h33; memOv[24'h000003] = 8'h44;
    memOv[24'h000100] = 8'hA0; memOv[24'h000101] = 8'hA1;
    memOv[24'h000102] = 8'hA2; memOv[24'h000103] = 8'hA3;
    memOv[24'h000104] = 8'hB0; memOv[24'h000105] = 8'hB1;
    memOv[24'h000106] = 8'hB2; memOv[24'h000107] = 8'hB3;
    memOv[24'h000108] = 8'hD0; memOv[24'h000109] = 8'hD1;
    memOv[24'h00010A] = 8'hD2; memOv[24'h00010B] = 8'hD3;
    memOv[24'h000200] = 8'hC0; memOv[24'h000201] = 8'hC1;
    memOv[24'h000202] = 8'hC2; memOv[24'h000203] = 8'hC3;
    memOv[24'hFFFFFC] = 8'hF0; memOv[24'hFFFFFD] = 8'hF1;
    memOv[24'hFFFFFE] = 8'hF2; memOv[24'hFFFFFF] = 8'hF3;

    tbl[0] = '{24'h000000,  0, 57, 32'h44332211, 1'b1, 0};
    tbl[1] = '{24'h000100, 25, 57, 32'hA3A2A1A0, 1'b1, 0};
    tbl[2] = '{24'h000104,  3, 17, 32'hB3B2B1B0, 1'b0, 0};
    tbl[3] = '{24'h000108, 15, 17, 32'hD3D2D1D0, 1'b0, 0};
    tbl[4] = '{24'h000200,  5, 61, 32'hC3C2C1C0, 1'b1, 4};
    tbl[5] = '{24'hFFFFFC, 16, 57, 32'hF3F2F1F0, 1'b1, 0};
    tbl[6] = '{24'h000000,  0, 17, 32'h44332211, 1'b0, 0};
    tbl[7] = '{24'h000104, 40, 57, 32'hB3B2B1B0, 1'b1, 0};

    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset pins", 32'({spi_cs_n, spi_clk, spi_dq_oe, spi_dq_o, req_ready, rsp_valid, busy}),
                32'b1_0_0000_0000_000);
    checkOutput("reset rsp_data", rsp_data, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("ready at release", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready after release", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (tbl[i].gap) @(negedge clk);
      applyStimulus(tbl[i].addr, tbl[i].expLat, tbl[i].expData, tbl[i].expNew, $sformatf("vec%0d", i));
      if (tbl[i].expCsHigh != 0)
        checkOutput($sformatf("vec%0d cs high", i), 32'(lastCsHigh), 32'(tbl[i].expCsHigh));
    end

    // Idle after a read: HOLD times out, then DESEL, then IDLE.
    riseAt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (riseAt < 0 && spi_cs_n) riseAt = k;
      if (k == 1) checkOutput("rsp one cycle", 32'(rsp_valid), 32'd0);
      if (k == 19) checkOutput("busy in desel", 32'(busy), 32'd1);
      if (k == 20) begin
        checkOutput("busy idle", 32'(busy), 32'd0);
        checkOutput("ready idle", 32'(req_ready), 32'd1);
        checkOutput("rsp_data held", rsp_data, 32'hB3B2B1B0);
      end
    end
    checkOutput("hold timeout", 32'(riseAt), 32'(HOLD_CYCLES));

    // Reset in the middle of the address phase.
    req_addr  = 24'h000100;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("mid addr pins", 32'({spi_cs_n, spi_clk, spi_dq_oe}), 32'b0_1_1111);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort pins", 32'({spi_cs_n, spi_clk, spi_dq_oe, spi_dq_o, req_ready, rsp_valid, busy}),
                32'b1_0_0000_0000_000);
    sawRsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    reset_n = 1'b1;
    checkOutput("abort no rsp", 32'(sawRsp), 32'd0);
    checkOutput("abort ready at release", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("abort ready after", 32'(req_ready), 32'd1);
    applyStimulus(24'h000000, 1 + TXN_CLKS, 32'h44332211, 1'b1, "after reset");

    // Randomized traffic against the transaction-level model.
    prevAddr = 24'h000000;
    for (int i = 0; i < 24; i++) begin
      gap = int'($urandom_range(0, 22));
      if ($urandom_range(0, 3) < 2) a = prevAddr + 24'd4;
      else a = 24'($urandom()) & 24'hFFFFFC;
      inHold = (gap < HOLD_CYCLES);
      cont   = inHold && (a[23:2] == prevAddr[23:2] + 22'd1);
      if (cont) lat = 1 + 2 * 8;
      else if (inHold) lat = 1 + CS_HIGH_MIN + TXN_CLKS;
      else lat = 1 + TXN_CLKS;
      repeat (gap) @(negedge clk);
      applyStimulus(a, lat, wordAt(a), !cont, $sformatf("rand%0d", i));
      prevAddr = a;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
